// File: rtl/hilo_div_unit.sv
// ---------------------------------------------------------------------------
// hilo_div_unit
//
// HI/LO register pair with an iterative restoring divider.
//   - MTHI/MTLO path (memory stage): hilowriteM with hilo_selM writes HI
//     (bit 1) and/or LO (bit 0) on the next edge, in any divider state.
//   - Divide path (execute stage): div_startE in IDLE latches the operands.
//     The unit then spends WIDTH cycles in BUSY, one quotient bit per cycle,
//     and one cycle in DONE. Leaving DONE writes LO=quotient, HI=remainder.
//     A zero divisor skips the iterations: LO=all-ones, HI=dividend.
//   - flushE in BUSY aborts the divide with no HI/LO write. A flush in DONE
//     does not cancel the result write.
//
// Optional feature: define HILO_SIGNED_DIV_EN to honour div_signedE.
// Signed divides work on operand magnitudes and fix up the signs at the end.
// Without the macro, div_signedE is ignored and every divide is unsigned.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   hilowriteM    direct HI/LO write enable
//   hilo_selM     [1]=write HI, [0]=write LO
//   hiwdataM      HI write data
//   lowdataM      LO write data
//   div_startE    divide request
//   div_signedE   signed divide request (used only with HILO_SIGNED_DIV_EN)
//   div_aE        dividend
//   div_bE        divisor
//   flushE        execute-stage flush
//   div_stallE    stall request to the hazard unit (combinational)
//   div_done      one-cycle completion pulse, high while in DONE
//   hi_o, lo_o    HI / LO registers
//   div_state_o   divider FSM state (0=IDLE, 1=BUSY, 2=DONE), for debug
//
// Handshake: a divide is accepted in the cycle where the FSM is IDLE,
// div_startE=1 and flushE=0. div_stallE is high in that cycle and in every
// BUSY cycle, so the requesting instruction stays in the execute stage until
// the result is about to be written.
// ---------------------------------------------------------------------------
module hilo_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hilowriteM,
    input  logic [1:0]       hilo_selM,
    input  logic [WIDTH-1:0] hiwdataM,
    input  logic [WIDTH-1:0] lowdataM,
    input  logic             div_startE,
    input  logic             div_signedE,
    input  logic [WIDTH-1:0] div_aE,
    input  logic [WIDTH-1:0] div_bE,
    input  logic             flushE,
    output logic             div_stallE,
    output logic             div_done,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [1:0]       div_state_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] quot_q;     // holds the dividend, shifts into the quotient
    logic [WIDTH-1:0] rem_q;      // partial remainder
    logic [WIDTH-1:0] dvs_q;      // divisor (magnitude)
    logic             dz_q;       // divisor was zero
    logic             div_done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    // Operand magnitudes presented to the iterative core.
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

`ifdef HILO_SIGNED_DIV_EN
    logic a_neg;
    logic b_neg;
    logic neg_quot_q;             // operand signs differ
    logic neg_rem_q;              // dividend was negative

    always_comb begin
        a_neg = div_signedE & div_aE[WIDTH-1];
        b_neg = div_signedE & div_bE[WIDTH-1];
        a_mag = a_neg ? -div_aE : div_aE;
        b_mag = b_neg ? -div_bE : div_bE;
    end
`else
    logic unused_signed;

    assign a_mag         = div_aE;
    assign b_mag         = div_bE;
    assign unused_signed = div_signedE;
`endif

    // One restoring-division step. The partial remainder is always below the
    // divisor, so the shifted value fits in WIDTH+1 bits and the top bit of
    // the trial difference is the borrow.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quot_d;

    always_comb begin
        shifted = {rem_q, quot_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (trial[WIDTH]) begin
            rem_d  = shifted[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_d  = trial[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b1};
        end
    end

    // Final HI/LO values written when leaving DONE. For a zero divisor the
    // remainder register carries the dividend magnitude; restoring the
    // dividend's sign gives back the raw dividend.
    logic [WIDTH-1:0] lo_d;
    logic [WIDTH-1:0] hi_d;

    always_comb begin
        lo_d = dz_q ? {WIDTH{1'b1}} : quot_q;
        hi_d = rem_q;
`ifdef HILO_SIGNED_DIV_EN
        if (!dz_q && neg_quot_q) lo_d = -quot_q;
        if (neg_rem_q)           hi_d = -rem_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            dz_q       <= 1'b0;
            div_done_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
`ifdef HILO_SIGNED_DIV_EN
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            div_done_q <= 1'b0;

            // Direct write first; a DONE write below overrides it.
            if (hilowriteM) begin
                if (hilo_selM[1]) hi_q <= hiwdataM;
                if (hilo_selM[0]) lo_q <= lowdataM;
            end

            case (state_q)
                S_IDLE: begin
                    if (div_startE && !flushE) begin
                        quot_q  <= a_mag;
                        dvs_q   <= b_mag;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        dz_q    <= (div_bE == '0);
`ifdef HILO_SIGNED_DIV_EN
                        neg_quot_q <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
`endif
                        state_q <= S_BUSY;
                    end
                end

                S_BUSY: begin
                    if (flushE) begin
                        state_q <= S_IDLE;
                    end else if (dz_q) begin
                        rem_q      <= quot_q;
                        state_q    <= S_DONE;
                        div_done_q <= 1'b1;
                    end else begin
                        rem_q  <= rem_d;
                        quot_q <= quot_d;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q    <= S_DONE;
                            div_done_q <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign div_stallE  = ((state_q == S_IDLE) && div_startE && !flushE) ||
                         (state_q == S_BUSY);
    assign div_done    = div_done_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign div_state_o = state_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// ---------------------------------------------------------------------------
// tb_hilo_div_unit
//
// Self-checking bench for hilo_div_unit. Each divide pushes its expected
// {HI, LO} into exp_q when it is issued; the entry is popped and compared
// once the result has been written. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_hilo_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         hilowriteM = 1'b0;
    logic [1:0]   hilo_selM = 2'b00;
    logic [W-1:0] hiwdataM = '0;
    logic [W-1:0] lowdataM = '0;
    logic         div_startE = 1'b0;
    logic         div_signedE = 1'b0;
    logic [W-1:0] div_aE = '0;
    logic [W-1:0] div_bE = '0;
    logic         flushE = 1'b0;
    logic         div_stallE;
    logic         div_done;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;
    logic [1:0]   dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    logic [2*W-1:0] exp_q[$];

    hilo_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .hilowriteM  (hilowriteM),
        .hilo_selM   (hilo_selM),
        .hiwdataM    (hiwdataM),
        .lowdataM    (lowdataM),
        .div_startE  (div_startE),
        .div_signedE (div_signedE),
        .div_aE      (div_aE),
        .div_bE      (div_bE),
        .flushE      (flushE),
        .div_stallE  (div_stallE),
        .div_done    (div_done),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .div_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Returns {HI, LO}.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic s);
        logic [W-1:0] ma, mb, q, r;
        logic         sa, sb;
        if (b == '0) return {a, {W{1'b1}}};
        q = a / b;
        r = a % b;
`ifdef HILO_SIGNED_DIV_EN
        if (s) begin
            sa = a[W-1];
            sb = b[W-1];
            ma = sa ? -a : a;
            mb = sb ? -b : b;
            q  = ma / mb;
            r  = ma % mb;
            if (sa ^ sb) q = -q;
            if (sa)      r = -r;
        end
`else
        sa = s; sb = s; ma = '0; mb = '0;
`endif
        return {r, q};
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after a rising edge with the DUT in IDLE. Returns one
    // cycle after the start cycle (the first BUSY cycle).
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input bit push);
        div_aE      = a;
        div_bE      = b;
        div_signedE = s;
        div_startE  = 1'b1;
        if (push) exp_q.push_back(model(a, b, s));
        @(negedge clk);
        n_total++;
        if (div_stallE !== 1'b1)
            $display("FAIL start_stall: got %b expected 1", div_stallE);
        else n_pass++;
        tick();
        div_startE  = 1'b0;
        div_aE      = $urandom;
        div_bE      = $urandom;
        div_signedE = 1'($urandom_range(0, 1));
    endtask

    // Waits for div_done, checking latency (cycles after the start cycle),
    // busy stall, the one-cycle pulse and the written HI/LO. During BUSY the
    // operands and div_startE are scrambled, which the DUT must ignore.
    task automatic run_to_done(input int k_start, input int exp_lat,
                               input bit coincide, input bit flush_done);
        int             k;
        bit             seen;
        bit             stall_ok;
        logic [2*W-1:0] exp;
        k = k_start; seen = 0; stall_ok = 1;
        while (!seen && k <= W + 8) begin
            @(negedge clk);
            if (div_done === 1'b1) begin
                seen = 1;
            end else begin
                if (div_stallE !== 1'b1) stall_ok = 0;
                tick();
                div_startE = 1'($urandom_range(0, 1));
                div_aE     = $urandom;
                div_bE     = $urandom;
                k++;
            end
        end
        div_startE = 1'b0;
        n_total++;
        if (!seen || k != exp_lat)
            $display("FAIL done_latency: got cycle %0d (seen=%0d) expected %0d", k, seen, exp_lat);
        else n_pass++;
        n_total++;
        if (stall_ok !== 1'b1)
            $display("FAIL busy_stall: got a low stall in BUSY expected 1");
        else n_pass++;
        n_total++;
        if (div_stallE !== 1'b0)
            $display("FAIL done_stall: got %b expected 0", div_stallE);
        else n_pass++;
        if (coincide) begin
            hilowriteM = 1'b1;
            hilo_selM  = 2'b11;
            hiwdataM   = $urandom;
            lowdataM   = $urandom;
        end
        if (flush_done) flushE = 1'b1;
        tick();
        hilowriteM = 1'b0;
        flushE     = 1'b0;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_total++;
        if ({hi_o, lo_o} !== exp)
            $display("FAIL result: got hi=%h lo=%h expected hi=%h lo=%h", hi_o, lo_o, exp[2*W-1:W], exp[W-1:0]);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (div_done !== 1'b0 || div_stallE !== 1'b0)
            $display("FAIL after_done: got done=%b stall=%b expected 0 0", div_done, div_stallE);
        else n_pass++;
        tick();
    endtask

    task automatic direct_write(input logic [1:0] sel, input logic [W-1:0] hd,
                                input logic [W-1:0] ld);
        hilowriteM = 1'b1;
        hilo_selM  = sel;
        hiwdataM   = hd;
        lowdataM   = ld;
        tick();
        hilowriteM = 1'b0;
    endtask

    // Counts div_done pulses over n cycles; used where none may appear.
    task automatic watch_no_done(input int n, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (div_done === 1'b1) seen = 1;
            tick();
        end
        n_total++;
        if (seen) $display("FAIL %s: got a div_done pulse expected none", name);
        else n_pass++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (hi_o !== '0) $display("FAIL reset_hi: got %h expected 0", hi_o); else n_pass++;
        n_total++;
        if (lo_o !== '0) $display("FAIL reset_lo: got %h expected 0", lo_o); else n_pass++;
        n_total++;
        if (div_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", div_done); else n_pass++;
        n_total++;
        if (div_stallE !== 1'b0) $display("FAIL reset_stall: got %b expected 0", div_stallE); else n_pass++;
        tick();
    endtask

    task automatic test_unsigned();
        logic [W-1:0] a_tab [4] = '{32'd100, 32'd5, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
        logic [W-1:0] b_tab [4] = '{32'd7,   32'd9, 32'd1,         32'h0000_1234};
        for (int i = 0; i < 4; i++) begin
            issue(a_tab[i], b_tab[i], 1'b0, 1'b1);
            run_to_done(1, W + 1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            issue($urandom, 32'($urandom_range(1, 1000)), 1'b0, 1'b1);
            run_to_done(1, W + 1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_div_zero();
        issue(32'h0000_1234, 32'h0, 1'b0, 1'b1);
        run_to_done(1, 2, 1'b0, 1'b0);
    endtask

    task automatic test_direct_write();
        direct_write(2'b11, 32'h1111_1111, 32'h2222_2222);
        direct_write(2'b10, 32'hDEAD_BEEF, 32'h3333_3333);
        @(negedge clk);
        n_total++;
        if (hi_o !== 32'hDEAD_BEEF) $display("FAIL mthi_hi: got %h expected deadbeef", hi_o); else n_pass++;
        n_total++;
        if (lo_o !== 32'h2222_2222) $display("FAIL mthi_lo: got %h expected 22222222", lo_o); else n_pass++;
        tick();
        direct_write(2'b01, 32'h4444_4444, 32'h5555_5555);
        @(negedge clk);
        n_total++;
        if ({hi_o, lo_o} !== {32'hDEAD_BEEF, 32'h5555_5555})
            $display("FAIL mtlo: got hi=%h lo=%h expected hi=deadbeef lo=55555555", hi_o, lo_o);
        else n_pass++;
        tick();
    endtask

    // A direct write in BUSY lands; one coinciding with DONE loses.
    task automatic test_coincident();
        issue(32'd1000, 32'd9, 1'b0, 1'b1);
        direct_write(2'b11, 32'hCAFE_0001, 32'hCAFE_0002);
        @(negedge clk);
        n_total++;
        if ({hi_o, lo_o} !== {32'hCAFE_0001, 32'hCAFE_0002})
            $display("FAIL busy_write: got hi=%h lo=%h expected hi=cafe0001 lo=cafe0002", hi_o, lo_o);
        else n_pass++;
        tick();
        run_to_done(3, W + 1, 1'b1, 1'b0);
    endtask

    task automatic test_flush_done();
        issue(32'd77777, 32'd13, 1'b0, 1'b1);
        run_to_done(1, W + 1, 1'b0, 1'b1);
    endtask

    task automatic test_flush();
        direct_write(2'b11, 32'd5, 32'd5);
        issue(32'd50, 32'd3, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) tick();
        flushE = 1'b1;
        @(negedge clk);
        n_total++;
        if (div_stallE !== 1'b1) $display("FAIL flush_cycle_stall: got %b expected 1", div_stallE); else n_pass++;
        tick();
        flushE = 1'b0;
        @(negedge clk);
        n_total++;
        if (div_stallE !== 1'b0) $display("FAIL flush_idle: got stall %b expected 0", div_stallE); else n_pass++;
        tick();
        watch_no_done(W + 4, "flush_no_done");
        @(negedge clk);
        n_total++;
        if ({hi_o, lo_o} !== {32'd5, 32'd5})
            $display("FAIL flush_hilo: got hi=%h lo=%h expected 5 5", hi_o, lo_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_signed();
        logic [W-1:0] a_tab [4] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFB, 32'd7};
        logic [W-1:0] b_tab [4] = '{32'd2,         32'hFFFF_FFFF, 32'h0,        32'hFFFF_FFFE};
        for (int i = 0; i < 4; i++) begin
            issue(a_tab[i], b_tab[i], 1'b1, 1'b1);
            run_to_done(1, (b_tab[i] == '0) ? 2 : W + 1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        for (int i = 0; i < 5; i++) begin
            a = $urandom;
            b = (i == 4) ? 32'h0 : 32'($urandom >> $urandom_range(0, 28));
            issue(a, b, 1'($urandom_range(0, 1)), 1'b1);
            run_to_done(1, (b == '0) ? 2 : W + 1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_busy();
        direct_write(2'b11, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
        issue(32'd999, 32'd4, 1'b0, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({hi_o, lo_o} !== '0)
            $display("FAIL midreset_hilo: got hi=%h lo=%h expected 0 0", hi_o, lo_o);
        else n_pass++;
        n_total++;
        if (div_stallE !== 1'b0) $display("FAIL midreset_stall: got %b expected 0", div_stallE); else n_pass++;
        tick();
        watch_no_done(W + 4, "midreset_no_done");
        @(negedge clk);
        n_total++;
        if ({hi_o, lo_o} !== '0)
            $display("FAIL midreset_final: got hi=%h lo=%h expected 0 0", hi_o, lo_o);
        else n_pass++;
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_unsigned();
        test_div_zero();
        test_direct_write();
        test_coincident();
        test_flush_done();
        test_flush();
        test_signed();
        test_back_to_back();
        test_reset_mid_busy();
        n_total++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
